// File: rtl/cic_pkg.sv
// Shared sizing helpers for the CIC interpolator.
// Width derivations live here so the top and tests agree.
package cic_pkg;

    function automatic int cic_out_width(int width, int stages, int rate);
        return width + stages * $clog2(rate);
    endfunction

    function automatic int cic_ph_width(int rate);
        return ($clog2(rate) < 1) ? 1 : $clog2(rate);
    endfunction

endpackage

// File: rtl/cic_integ_stage.sv
// One integrator section: wrapping accumulator with enable
// and synchronous active-low clear.
module cic_integ_stage
    import cic_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    assign acc_d = en_i ? acc_q + d_i : acc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign q_o = acc_q;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate comb chain, zero stuffing by RATE,
// then a registered integrator pipeline at the high rate.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 3,
    parameter int RATE      = 4,
    parameter int OUT_WIDTH = cic_out_width(WIDTH, STAGES, RATE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     x_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] y_out,
    output logic                 out_valid
);

    localparam int PW = cic_ph_width(RATE);

    typedef logic signed [OUT_WIDTH-1:0] sample_t;

    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;
    logic          out_valid_q;
    logic          accept;
    logic          active;
    sample_t       x_ext;

    logic [STAGES:0][OUT_WIDTH-1:0] c;
    logic [STAGES:0][OUT_WIDTH-1:0] s;

    assign in_ready = reset && (ph_q == '0);
    assign accept   = in_valid && in_ready;
    assign active   = accept || (ph_q != '0);

    always_comb begin
        ph_d = ph_q;
        if (active) begin
            ph_d = (ph_q == PW'(RATE - 1)) ? '0 : ph_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ph_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            out_valid_q <= active;
        end
    end

    assign x_ext = sample_t'($signed(x_in));
    assign c[0]  = x_ext;

    // Delays only load on accept, so the combs see the low-rate stream.
    for (genvar j = 0; j < STAGES; j++) begin : g_comb
        logic [OUT_WIDTH-1:0] d_q;
        assign c[j+1] = c[j] - d_q;
        always_ff @(posedge clock) begin
            if (!reset) begin
                d_q <= '0;
            end else if (accept) begin
                d_q <= c[j];
            end
        end
    end

    assign s[0] = accept ? c[STAGES] : '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_integ
        cic_integ_stage #(
            .W(OUT_WIDTH)
        ) u_stage (
            .clk_i (clock),
            .rst_ni(reset),
            .en_i  (active),
            .d_i   (s[k]),
            .q_o   (s[k+1])
        );
    end

    assign y_out     = s[STAGES];
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Randomized bench for cic_interpolator against a convolution
// model built from the boxcar^N impulse response.
module tb_cic_interpolator;

    localparam int W   = 32;
    localparam int N   = 3;
    localparam int R   = 4;
    localparam int OW  = W + N * $clog2(R);
    localparam int W8  = 8;
    localparam int OW8 = W8 + N * $clog2(R);
    localparam int HL  = N * (R - 1) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  x_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] y_out;
    logic          out_valid;
    logic [W8-1:0] x_in8 = '0;
    logic          in_valid8 = 1'b0;
    logic          in_ready8;
    logic [OW8-1:0] y_out8;
    logic          out_valid8;

    always #5 clock = ~clock;

    cic_interpolator #(.WIDTH(W), .STAGES(N), .RATE(R)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .x_in     (x_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y_out    (y_out),
        .out_valid(out_valid)
    );

    cic_interpolator #(.WIDTH(W8), .STAGES(N), .RATE(R)) u_dut8 (
        .clock    (clock),
        .reset    (reset),
        .x_in     (x_in8),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .y_out    (y_out8),
        .out_valid(out_valid8)
    );

    int     total = 0;
    int     bad = 0;
    int     rdy_hi = 0;
    longint h [HL];
    longint xs [2][4096];
    int     na [2];
    int     ne [2];
    int     ph [2];
    longint ey [2];
    bit     ev [2];
    longint obs [$];

    task automatic check(input string tag, input longint got,
                         input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap(input longint v, input int ow);
        longint t;
        t = v <<< (64 - ow);
        return t >>> (64 - ow);
    endfunction

    // y after active edge e = sum of accepted x[a] * h[e-(N-1)-a*R]
    function automatic longint model(input int l, input int e,
                                     input int ow);
        longint sum = 0;
        for (int a = 0; a < na[l]; a++) begin
            int k = e - (N - 1) - a * R;
            if (k >= 0 && k < HL) sum += xs[l][a] * h[k];
        end
        return wrap(sum, ow);
    endfunction

    task automatic lane_edge(input int l, input bit v, input longint x,
                             input bit rs, input int ow);
        bit acc;
        bit act;
        if (!rs) begin
            ph[l] = 0; na[l] = 0; ne[l] = 0; ey[l] = 0; ev[l] = 0;
            return;
        end
        acc = v && (ph[l] == 0);
        act = acc || (ph[l] != 0);
        if (acc) begin
            xs[l][na[l]] = x;
            na[l]++;
        end
        if (act) begin
            ey[l] = model(l, ne[l], ow);
            ne[l]++;
            ph[l] = (ph[l] + 1) % R;
        end
        ev[l] = act;
    endtask

    task automatic cyc(input bit rs, input bit v, input longint x,
                       input bit v8 = 1'b0, input longint x8 = 0);
        @(negedge clock);
        reset = rs; in_valid = v; x_in = x[W-1:0];
        in_valid8 = v8; x_in8 = x8[W8-1:0];
        #1;
        check("rdy", longint'(in_ready), longint'(ph[0] == 0 && rs));
        check("rdy8", longint'(in_ready8), longint'(ph[1] == 0 && rs));
        if (in_ready) rdy_hi++;
        @(posedge clock);
        lane_edge(0, v, x, rs, OW);
        lane_edge(1, v8, x8, rs, OW8);
        #1;
        check("val", longint'(out_valid), longint'(ev[0]));
        check("y", longint'($signed(y_out)), ey[0]);
        check("val8", longint'(out_valid8), longint'(ev[1]));
        check("y8", longint'($signed(y_out8)), ey[1]);
    endtask

    task automatic run_impulse(input string tag);
        longint tbl [13] = '{0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};
        longint sum = 0;
        obs.delete();
        cyc(1'b1, 1'b1, 1);
        if (out_valid) obs.push_back(longint'($signed(y_out)));
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 0);
            if (out_valid) obs.push_back(longint'($signed(y_out)));
        end
        check({tag, "_len"}, longint'(obs.size() >= 13), 1);
        for (int i = 0; i < 13 && i < obs.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), obs[i], tbl[i]);
            sum += obs[i];
        end
        check({tag, "_sum"}, sum, 64);
    endtask

    initial begin
        longint tmp [HL];
        int     len;
        longint held;
        int     lows;

        for (int i = 0; i < HL; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        for (int st = 0; st < N; st++) begin
            for (int i = 0; i < HL; i++) begin
                tmp[i] = 0;
                for (int j = 0; j < R; j++)
                    if (i - j >= 0) tmp[i] += h[i-j];
            end
            len += R - 1;
            for (int i = 0; i < HL; i++) h[i] = (i < len) ? tmp[i] : 0;
        end
        for (int l = 0; l < 2; l++) begin
            na[l] = 0; ne[l] = 0; ph[l] = 0; ey[l] = 0; ev[l] = 0;
        end

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 7, 1'b1, 5);

        run_impulse("imp");

        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 100);
        rdy_hi = 0;
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 100);
        check("dc_y", longint'($signed(y_out)), 1600);
        check("dc_rdy", rdy_hi, 10);

        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'b1, longint'($signed($urandom())));
        for (int i = 0; i < 8 && ph[0] != 0; i++)
            cyc(1'b1, 1'b1, longint'($signed($urandom())));
        held = longint'($signed(y_out));
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 0);
            if (!out_valid) lows++;
        end
        check("stall_lows", lows, 5);
        check("stall_hold", longint'($signed(y_out)), held);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'b1, longint'($signed($urandom())));

        for (int i = 0; i < 8 && ph[0] != 2; i++) cyc(1'b1, 1'b1, 55);
        check("mid_ph", ph[0], 2);
        cyc(1'b0, 1'b1, 55);
        check("mid_y", longint'($signed(y_out)), 0);
        check("mid_val", longint'(out_valid), 0);
        run_impulse("imp2");

        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 0, 1'b1, -128);
        check("wrap_y8", longint'($signed(y_out8)), -2048);

        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, ($urandom_range(0, 9) != 0),
                longint'($signed($urandom())),
                ($urandom_range(0, 9) != 0),
                longint'($urandom_range(0, 255)) - 128);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Cascaded integrator-comb interpolator: the transmit-side counterpart of the CIC decimation filter. It accepts one signed sample per RATE clocks through a valid/ready handshake and runs STAGES comb sections at the low rate. Each comb output is zero-stuffed by RATE and passed through STAGES integrator sections, producing one output sample per active clock. It sits between the low-rate sample source and the high-rate DAC/modulator path.

## Interface
- WIDTH, 32: input sample width, signed two's complement.
- STAGES, 3: number of comb sections and number of integrator sections (N); range 1..8.
- RATE, 4: interpolation factor R; range 2..256. Differential delay M is fixed at 1.
- OUT_WIDTH, WIDTH + STAGES*$clog2(RATE): output and internal register width.

- clock, input, 1: single clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-low reset.
- x_in, input, WIDTH: input sample, signed.
- in_valid, input, 1: x_in is valid.
- in_ready, output, 1: block can accept a sample this cycle.
- y_out, output, OUT_WIDTH: output sample, signed.
- out_valid, output, 1: y_out holds a new sample.

## Operation
- Phase counter ph cycles 0..RATE-1. in_ready = (ph == 0) and not in reset.
- Accept = in_valid & in_ready. Active = accept | (ph != 0).
- On accept, x_in is sign-extended to OUT_WIDTH and drives comb chain. Comb j output = input_j − d_j; d_j loads input_j on accept only. Combs are combinational differences over registered delays.
- Integrator input u = final comb output when accept, else 0 (zero stuffing).
- Integrators are a registered pipeline gated by active: i1 <= i1 + u; ik <= ik + i(k−1) using the pre-edge value. y_out = i_N.
- ph advances on every active cycle and wraps RATE-1 → 0.
- At ph == 0 with in_valid low, the block stalls: no registers change and out_valid goes low on the next cycle. Upstream underrun is tolerated, not an error.
- Arithmetic: all internal registers are OUT_WIDTH bits with modular (wrapping) two's complement. Intermediate integrator overflow is permitted; the final result is exact when the true output fits in OUT_WIDTH.
- DC gain is RATE^(STAGES−1). There is no gain compensation inside the block.

## Timing
- Reset (reset == 0 at an edge) sets ph, all comb delays, all integrators, y_out and out_valid to 0. in_ready is 0 while reset is low.
- Reset mid-burst discards the in-flight sample and zero-stuff phase. The first cycle after reset release has in_ready = 1.
- out_valid is registered: high the cycle after each active edge, else low.
- An impulse at x_in first appears at y_out after the STAGES-th active edge following its accept.
- Throughput is one input per RATE clocks and one output per clock while fed continuously. in_ready then pulses 1 of every RATE cycles.
- With in_valid held high, an accept occurs exactly every RATE cycles with no bubble, and out_valid stays continuously high.

## Structure
- Package cic_pkg holds:
  - function cic_out_width(WIDTH, STAGES, RATE);
  - the phase-counter width constant derivation ($clog2(RATE), minimum 1);
  - a signed sample typedef parameterised via localparam in the module.
- One sub-module, cic_integ_stage: an OUT_WIDTH accumulator with enable and synchronous active-low clear. It is instantiated STAGES times in a generate loop.
- Comb sections are inline in a generate loop with no separate module.

## Test plan
- Reset: hold reset low 3 cycles with in_valid = 1 → y_out = 0, out_valid = 0, in_ready = 0. After release, in_ready = 1 on the first cycle.
- Impulse, defaults: x_in = 1 once, then 0 continuously → y_out on successive valid cycles is 0,0,1,3,6,10,12,12,10,6,3,1,0. The sum of nonzero values is 64.
- DC, defaults: x_in = 100 continuously → y_out settles at 1600 after 12 valid cycles and stays there. in_ready is high exactly 1 cycle in 4.
- Underrun: drop in_valid for 5 cycles at ph == 0 mid-stream → out_valid low for exactly those cycles, and y_out holds its value. The output sequence resumes identical to an unstalled run.
- Wrap/extremes: WIDTH = 8, x_in = −128 continuously → y_out settles at −2048 (OUT_WIDTH = 14) with no sign error despite intermediate wrap.
- Reset mid-burst: assert reset at ph == 2 → all outputs 0 next cycle. The impulse test rerun afterwards matches the clean result.
